// File: rtl/ex_alu_unit_if.sv
// Request/response bundle between the execute-stage pipeline and ex_alu_unit.
// The pipeline drives the request signals; the ALU returns results and status.
interface ex_alu_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUcontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUcontrol, a, b,
        input  result, zero, overflow, busy, done
    );

    modport slave (
        input  start, ALUcontrol, a, b,
        output result, zero, overflow, busy, done
    );
endinterface

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, with a registered result and flags.
// Define ALU_MUL_EN to add the iterative shift-add multiply for code 1000.
module ex_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    ex_alu_unit_if.slave  bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int         CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;
`else
    typedef enum logic {IDLE} state_t;
`endif

    state_t state_reg, state_next;

    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;
    logic             ovf_reg, ovf_next;
    logic             done_reg, done_next;

    logic [WIDTH-1:0] and_v, or_v, nor_v;
    logic [WIDTH-1:0] sum, diff;
    logic             slt;
    logic [WIDTH-1:0] op_res;
    logic             op_ovf;

`ifdef ALU_MUL_EN
    logic             busy_reg, busy_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_v[gi] = bus.a[gi] & bus.b[gi];
            assign or_v[gi]  = bus.a[gi] | bus.b[gi];
            assign nor_v[gi] = ~(bus.a[gi] | bus.b[gi]);
        end
    endgenerate

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;
    // Signed compare directly, so SLT stays correct when a-b overflows.
    assign slt  = $signed(bus.a) < $signed(bus.b);

    always_comb begin
        op_res = '0;
        op_ovf = 1'b0;
        case (bus.ALUcontrol)
            OP_AND: op_res = and_v;
            OP_OR:  op_res = or_v;
            OP_NOR: op_res = nor_v;
            OP_ADD: begin
                op_res = sum;
                op_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res = diff;
                op_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                         (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT: op_res = {{(WIDTH-1){1'b0}}, slt};
            default: begin
                op_res = '0;
                op_ovf = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;
`ifdef ALU_MUL_EN
        busy_next   = busy_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        acc_sum     = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
`ifdef ALU_MUL_EN
                    if (bus.ALUcontrol == OP_MUL) begin
                        mcand_next  = bus.a;
                        mplier_next = bus.b;
                        acc_next    = '0;
                        cnt_next    = '0;
                        busy_next   = 1'b1;
                        state_next  = MUL;
                    end else
`endif
                    begin
                        result_next = op_res;
                        zero_next   = (op_res == '0);
                        ovf_next    = op_ovf;
                        done_next   = 1'b1;
                    end
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                // One multiplier bit per cycle; the last iteration retires directly.
                acc_next    = acc_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    result_next = acc_sum;
                    zero_next   = (acc_sum == '0);
                    ovf_next    = 1'b0;
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                    state_next  = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            zero_reg   <= 1'b1;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg   <= 1'b0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            busy_reg   <= busy_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign bus.busy = busy_reg;
`else
    assign bus.busy = 1'b0;
`endif

    assign bus.result   = result_reg;
    assign bus.zero     = zero_reg;
    assign bus.overflow = ovf_reg;
    assign bus.done     = done_reg;
endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed bench for ex_alu_unit: vector table for single-cycle ops plus
// hand-written reset, back-to-back and (with ALU_MUL_EN) multiply sequences.
module tb_ex_alu_unit;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ex_alu_unit_if #(.WIDTH(32)) bus ();

    ex_alu_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, then sample 1ns after the following rising edge.
    task automatic apply(input logic [3:0] code, input logic [31:0] x, input logic [31:0] y,
                         input logic st);
        @(negedge clk);
        bus.start      = st;
        bus.ALUcontrol = code;
        bus.a          = x;
        bus.b          = y;
        @(posedge clk);
        #1;
    endtask

`ifdef ALU_MUL_EN
    task automatic run_mul(input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp, input logic poke);
        int busy_cnt;
        int done_at;
        int both;
        apply(OP_MUL, x, y, 1'b1);
        chk("mul_busy_after_start", {31'b0, bus.busy}, 32'd1);
        busy_cnt = bus.busy ? 1 : 0;
        done_at  = 0;
        both     = 0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            apply(poke ? OP_ADD : OP_MUL, 32'd1, 32'd2, poke && (k == 3));
            if (bus.done && bus.busy) both++;
            if (bus.busy) busy_cnt++;
            if (bus.done) done_at = k;
        end
        chk("mul_done_latency", done_at, 32'd32);
        chk("mul_busy_cycles", busy_cnt, 32'd32);
        chk("mul_done_with_busy", both, 32'd0);
        chk("mul_result", bus.result, exp);
        chk("mul_zero", {31'b0, bus.zero}, {31'b0, (exp == 32'd0)});
        chk("mul_overflow", {31'b0, bus.overflow}, 32'd0);
        $display("mul %h*%h: result=%h done after %0d cycles", x, y, bus.result, done_at);
        apply(OP_MUL, x, y, 1'b0);
        chk("mul_done_pulse_one_cycle", {31'b0, bus.done}, 32'd0);
        chk("mul_result_hold", bus.result, exp);
    endtask
`endif

    initial begin
        int done_seen;

        vecs.push_back('{"add_ovf",   OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{"sub_zero",  OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"slt_neg",   OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"slt_pos",   OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"and",       OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0});
        vecs.push_back('{"or",        OP_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0});
        vecs.push_back('{"nor",       OP_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0});
        vecs.push_back('{"sub_ovf",   OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1});
        vecs.push_back('{"add_wrap",  OP_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{"sub_neg",   OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{"slt_ovf",   OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"add_plain", OP_ADD, 32'h00001234, 32'h00004321, 32'h00005555, 1'b0, 1'b0});
        vecs.push_back('{"bad_code",  4'b0011, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
`ifndef ALU_MUL_EN
        vecs.push_back('{"mul_off",   OP_MUL, 32'h00003039, 32'h000002A6, 32'h00000000, 1'b1, 1'b0});
`endif

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.ALUcontrol = OP_AND;
        bus.a          = '0;
        bus.b          = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", {31'b0, bus.zero}, 32'd1);
        chk("rst_overflow", {31'b0, bus.overflow}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(OP_ADD, 32'd7, 32'd9, 1'b0);
            chk("idle_result", bus.result, 32'd0);
            chk("idle_zero", {31'b0, bus.zero}, 32'd1);
            chk("idle_done", {31'b0, bus.done}, 32'd0);
        end

        foreach (vecs[i]) begin
            apply(vecs[i].code, vecs[i].a, vecs[i].b, 1'b1);
            $display("vec %s: a=%h b=%h result=%h zero=%b ovf=%b done=%b",
                     vecs[i].name, vecs[i].a, vecs[i].b, bus.result, bus.zero,
                     bus.overflow, bus.done);
            chk({vecs[i].name, "_result"}, bus.result, vecs[i].res);
            chk({vecs[i].name, "_zero"}, {31'b0, bus.zero}, {31'b0, vecs[i].z});
            chk({vecs[i].name, "_overflow"}, {31'b0, bus.overflow}, {31'b0, vecs[i].o});
            chk({vecs[i].name, "_done"}, {31'b0, bus.done}, 32'd1);
            chk({vecs[i].name, "_busy"}, {31'b0, bus.busy}, 32'd0);
            apply(OP_ADD, 32'hDEAD0000, 32'h0000BEEF, 1'b0);
            chk({vecs[i].name, "_hold_done"}, {31'b0, bus.done}, 32'd0);
            chk({vecs[i].name, "_hold_result"}, bus.result, vecs[i].res);
        end

        apply(OP_ADD, 32'd1, 32'd2, 1'b1);
        chk("b2b_add_done", {31'b0, bus.done}, 32'd1);
        chk("b2b_add_result", bus.result, 32'd3);
        apply(OP_SUB, 32'd9, 32'd4, 1'b1);
        chk("b2b_sub_done", {31'b0, bus.done}, 32'd1);
        chk("b2b_sub_result", bus.result, 32'd5);
        apply(OP_OR, 32'd8, 32'd1, 1'b1);
        chk("b2b_or_done", {31'b0, bus.done}, 32'd1);
        chk("b2b_or_result", bus.result, 32'd9);
        $display("back-to-back: last result=%h", bus.result);
        apply(OP_OR, 32'd8, 32'd1, 1'b0);
        chk("b2b_end_done", {31'b0, bus.done}, 32'd0);
        chk("b2b_end_result", bus.result, 32'd9);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_result", bus.result, 32'd0);
        chk("rst2_zero", {31'b0, bus.zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

`ifdef ALU_MUL_EN
        run_mul(32'd12345, 32'd678, 32'd8369910, 1'b1);
        run_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0);

        apply(OP_MUL, 32'd12345, 32'd678, 1'b1);
        for (int k = 1; k < 10; k++) apply(OP_MUL, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("mulrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mulrst_done", {31'b0, bus.done}, 32'd0);
        chk("mulrst_result", bus.result, 32'd0);
        chk("mulrst_zero", {31'b0, bus.zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            apply(OP_MUL, 32'd0, 32'd0, 1'b0);
            if (bus.done || bus.busy) done_seen++;
        end
        chk("mulrst_no_late_done", done_seen, 32'd0);
        $display("mul aborted by reset: result=%h", bus.result);
`else
        done_seen = 0;
        apply(OP_MUL, 32'd3, 32'd4, 1'b1);
        chk("muloff_done", {31'b0, bus.done}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            apply(OP_MUL, 32'd3, 32'd4, 1'b0);
            if (bus.busy || bus.done) done_seen++;
        end
        chk("muloff_quiet_after", done_seen, 32'd0);
`endif

        apply(OP_ADD, 32'd2, 32'd2, 1'b1);
        chk("post_add_result", bus.result, 32'd4);
        chk("post_add_done", {31'b0, bus.done}, 32'd1);
        $display("post add: result=%h", bus.result);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
